// File: rtl/llc_port_arbiter_pkg.sv
// llc_port_arbiter_pkg: shared FSM state encoding and arbitration mode values
package llc_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    localparam int RR_FIXED = 0;
    localparam int RR_ROUND = 1;
endpackage

// File: rtl/llc_port_arbiter_rr_pick.sv
// rr_pick: combinational winner select, first set req bit at or after ptr (wrapping)
// ports: req (request vector), ptr (search start), idx (winner), valid (any request)
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] j;
    // Scan offsets from farthest to nearest so the nearest set bit is written last
    always_comb begin
        idx = '0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N);
            if (req[j]) idx = j;
        end
    end
    assign valid = |req;
endmodule

// File: rtl/llc_port_arbiter.sv
// llc_port_arbiter: arbitrates NUM_REQ line requestors onto one memory port, one transaction at a time
// ports: req_i/we_i/addr_i/wdata_i per-channel requests; ready_o one-cycle completion pulse, rdata_o last read line;
//        mem_req/mem_we/mem_addr/mem_wdata to memory; mem_rdata/mem_ready from memory; mem_req_reset retire pulse
module llc_port_arbiter
    import llc_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 20,
    parameter int LINE_W  = 128,
    parameter int RR_MODE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*LINE_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        ready_o,
    output logic [LINE_W-1:0]         rdata_o,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LINE_W-1:0]         mem_wdata,
    input  logic [LINE_W-1:0]         mem_rdata,
    input  logic                      mem_ready,
    output logic                      mem_req_reset
);
    localparam int IW = $clog2(NUM_REQ);
    state_t        state;
    logic [IW-1:0] rr_ptr, win, base, pick_idx, next_ptr;
    logic          pick_valid;
    // Fixed priority is round-robin search that always starts at channel 0
    assign base = (RR_MODE == RR_ROUND) ? rr_ptr : '0;
    assign next_ptr = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_i),
        .ptr   (base),
        .idx   (pick_idx),
        .valid (pick_valid)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            win           <= '0;
            ready_o       <= '0;
            rdata_o       <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_req_reset <= 1'b0;
        end else begin
            ready_o       <= '0;
            mem_req_reset <= 1'b0;
            case (state)
                IDLE: if (pick_valid) begin
                    win       <= pick_idx;
                    rr_ptr    <= next_ptr;
                    mem_we    <= we_i[pick_idx];
                    mem_addr  <= addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
                    mem_wdata <= wdata_i[int'(pick_idx)*LINE_W +: LINE_W];
                    mem_req   <= 1'b1;
                    state     <= BUSY;
                end
                BUSY: if (mem_ready) begin
                    if (!mem_we) rdata_o <= mem_rdata;
                    ready_o       <= NUM_REQ'(1) << win;
                    mem_req_reset <= 1'b1;
                    mem_req       <= 1'b0;
                    state         <= RELEASE;
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_llc_port_arbiter.sv
// tb_llc_port_arbiter: randomized and directed checks of llc_port_arbiter against a transaction-level model
module tb_llc_port_arbiter;
    localparam int NR = 4;
    localparam int AW = 20;
    localparam int LW = 128;
    logic               clk = 0;
    logic               rst = 1;
    logic [NR-1:0]      req_i = '0, we_i = '0, ready_o;
    logic [NR*AW-1:0]   addr_i = '0;
    logic [NR*LW-1:0]   wdata_i = '0;
    logic [LW-1:0]      rdata_o, mem_wdata, mem_rdata = '0;
    logic               mem_req, mem_we, mem_ready = 0, mem_req_reset;
    logic [AW-1:0]      mem_addr;
    logic [1:0]         fp_req, fp_we, fp_ready;
    logic [2*AW-1:0]    fp_addr;
    logic [2*LW-1:0]    fp_wdata;
    logic [LW-1:0]      fp_rdata, fp_mwdata, fp_mrdata;
    logic [AW-1:0]      fp_maddr;
    logic               fp_mreq, fp_mwe, fp_rr;
    int n_pass = 0, n_tot = 0, hold = 0, fp_c0 = 0, fp_c1 = 0;
    bit resp_en = 0, cmp_en = 0;
    int m_phase = 0, m_owner = 0, m_ptr = 0;
    logic [NR-1:0] e_ready = '0;
    logic e_req = 0, e_we = 0, e_rr = 0;
    logic [AW-1:0] e_addr = '0;
    logic [LW-1:0] e_wdata = '0, e_rdata = '0;
    always #5 clk = ~clk;
    llc_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ready_o(ready_o), .rdata_o(rdata_o), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req_reset(mem_req_reset));
    assign fp_req = 2'b11;
    assign fp_we = 2'b00;
    assign fp_addr = {20'h00222, 20'h00111};
    assign fp_wdata = '0;
    assign fp_mrdata = 128'h1234;
    llc_port_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .req_i(fp_req), .we_i(fp_we), .addr_i(fp_addr), .wdata_i(fp_wdata),
        .ready_o(fp_ready), .rdata_o(fp_rdata), .mem_req(fp_mreq), .mem_we(fp_mwe), .mem_addr(fp_maddr),
        .mem_wdata(fp_mwdata), .mem_rdata(fp_mrdata), .mem_ready(fp_mreq), .mem_req_reset(fp_rr));
    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask
    // Transaction-level model: grant, wait for memory, pulse, one idle gap
    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_phase = 0; m_ptr = 0; e_req = 0; e_we = 0; e_addr = '0;
            e_wdata = '0; e_rdata = '0; e_ready = '0; e_rr = 0;
        end else begin
            e_ready = '0;
            e_rr = 0;
            if (m_phase == 0) begin
                w = -1;
                for (int k = 0; k < NR; k++) if (w < 0 && req_i[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
                if (w >= 0) begin
                    m_owner = w; m_ptr = (w + 1) % NR; e_req = 1; e_we = we_i[w];
                    e_addr = addr_i[w*AW +: AW]; e_wdata = wdata_i[w*LW +: LW]; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (mem_ready) begin
                    if (!e_we) e_rdata = mem_rdata;
                    e_ready = NR'(1) << m_owner; e_rr = 1; e_req = 0; m_phase = 2;
                end
            end else m_phase = 0;
        end
    end
    always @(negedge clk) if (cmp_en) begin
        chk("mem_req", LW'(mem_req), LW'(e_req));
        chk("mem_we", LW'(mem_we), LW'(e_we));
        chk("mem_addr", LW'(mem_addr), LW'(e_addr));
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("rdata_o", rdata_o, e_rdata);
        chk("ready_o", LW'(ready_o), LW'(e_ready));
        chk("mem_req_reset", LW'(mem_req_reset), LW'(e_rr));
        chk("ready_onehot", LW'($onehot0(ready_o)), LW'(1));
    end
    always @(negedge clk) if (!rst) begin
        if (fp_ready[0]) fp_c0++;
        if (fp_ready[1]) fp_c1++;
    end
    task automatic cycle();
        @(negedge clk);
        if (resp_en) begin
            if (mem_ready && hold > 0) hold--;
            else if (mem_ready) mem_ready = 0;
            else if (mem_req && $urandom_range(0, 2) == 0) begin
                mem_ready = 1;
                mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                hold = $urandom_range(0, 1);
            end
        end
    endtask
    task automatic do_reset();
        @(negedge clk); rst = 1; req_i = '0; mem_ready = 0;
        @(negedge clk); rst = 0;
    endtask
    task automatic do_txn(input logic [NR-1:0] r, output logic [NR-1:0] rdy);
        req_i = r;
        @(negedge clk); mem_ready = 1;
        @(negedge clk); rdy = ready_o; mem_ready = 0; req_i = '0;
        @(negedge clk);
    endtask
    initial begin
        logic [NR-1:0] rdy;
        int fc[NR];
        int sum;
        @(negedge clk); @(negedge clk);
        chk("rst_mem_req", LW'(mem_req), 0);
        chk("rst_ready", LW'(ready_o), 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_mem_addr", LW'(mem_addr), 0);
        rst = 0; cmp_en = 1;
        // single read on ch0
        req_i = 4'b0001; we_i = '0; addr_i[0 +: AW] = 20'h00040;
        @(negedge clk); req_i = '0;
        chk("rd_mem_req", LW'(mem_req), 1);
        chk("rd_mem_addr", LW'(mem_addr), 128'h40);
        chk("rd_mem_we", LW'(mem_we), 0);
        repeat (3) @(negedge clk);
        chk("rd_no_early_ready", LW'(ready_o), 0);
        mem_ready = 1; mem_rdata = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        @(negedge clk);
        chk("rd_ready", LW'(ready_o), 128'h1);
        chk("rd_rdata", rdata_o, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
        chk("rd_retire", LW'(mem_req_reset), 1);
        chk("rd_rel_mem_req", LW'(mem_req), 0);
        @(negedge clk); mem_ready = 0;
        chk("rd_ready_one_cycle", LW'(ready_o), 0);
        chk("rd_retire_one_cycle", LW'(mem_req_reset), 0);
        chk("rd_ignore_late_ready", LW'(mem_req), 0);
        // write on ch1
        @(negedge clk);
        req_i = 4'b0010; we_i = 4'b0010; addr_i[AW +: AW] = 20'h000A0;
        wdata_i[LW +: LW] = {4{32'h11111111}};
        @(negedge clk); req_i = '0;
        chk("wr_mem_we", LW'(mem_we), 1);
        chk("wr_mem_addr", LW'(mem_addr), 128'hA0);
        chk("wr_mem_wdata", mem_wdata, {4{32'h11111111}});
        mem_ready = 1; mem_rdata = {4{32'h55555555}};
        @(negedge clk); mem_ready = 0;
        chk("wr_ready", LW'(ready_o), 128'h2);
        chk("wr_rdata_kept", rdata_o, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
        @(negedge clk); we_i = '0;
        // wrap: grant ch2 so the pointer sits at 3, then 1001 -> ch3 then ch0
        do_txn(4'b0100, rdy); chk("wrap_pre", LW'(rdy), 128'h4);
        do_txn(4'b1001, rdy); chk("wrap_ch3", LW'(rdy), 128'h8);
        do_txn(4'b1001, rdy); chk("wrap_ch0", LW'(rdy), 128'h1);
        // collision from reset
        do_reset();
        do_txn(4'b0011, rdy); chk("coll_1", LW'(rdy), 128'h1);
        do_txn(4'b0011, rdy); chk("coll_2", LW'(rdy), 128'h2);
        do_txn(4'b0011, rdy); chk("coll_3", LW'(rdy), 128'h1);
        // reset in 2nd BUSY cycle drops the transaction
        req_i = 4'b0001;
        @(negedge clk); @(negedge clk); rst = 1; req_i = '0; mem_ready = 1;
        @(negedge clk); rst = 0; mem_ready = 0;
        chk("rstb_mem_req", LW'(mem_req), 0);
        chk("rstb_ready", LW'(ready_o), 0);
        @(negedge clk);
        chk("rstb_no_late_ready", LW'(ready_o), 0);
        chk("rstb_no_retire", LW'(mem_req_reset), 0);
        do_txn(4'b0100, rdy); chk("rstb_next", LW'(rdy), 128'h4);
        // randomized traffic with occasional resets
        resp_en = 1;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) req_i = NR'($urandom_range(0, 15));
            we_i = NR'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) begin
                addr_i[i*AW +: AW] = AW'($urandom());
                wdata_i[i*LW +: LW] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        // fairness under continuous requests
        cycle(); rst = 1;
        cycle(); rst = 0; req_i = '1;
        for (int i = 0; i < NR; i++) fc[i] = 0;
        sum = 0;
        for (int c = 0; c < 2000 && sum < 40; c++) begin
            cycle();
            for (int i = 0; i < NR; i++) if (ready_o[i]) begin fc[i]++; sum++; end
        end
        chk("fair_total", LW'(sum), 40);
        for (int i = 0; i < NR; i++) chk($sformatf("fair_ch%0d", i), LW'(fc[i]), 10);
        resp_en = 0; req_i = '0;
        @(posedge clk);
        chk("fp_ch1_never", LW'(fp_c1), 0);
        chk("fp_ch0_served", LW'(fp_c0 > 100), 1);
        cmp_en = 0;
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/llc_port_arbiter.md
LLC_PORT_ARBITER -- requirements
Module: llc_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requestor channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 20, physical line address width.
REQ-003 SHALL have parameter LINE_W, default 128, cache line width.
REQ-004 SHALL have parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-005 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port req_i  in  NUM_REQ  per-channel request level.
REQ-008 SHALL have port we_i  in  NUM_REQ  per-channel write enable (1 = line write).
REQ-009 SHALL have port addr_i  in  NUM_REQ*ADDR_W  packed per-channel line addresses.
REQ-010 SHALL have port wdata_i  in  NUM_REQ*LINE_W  packed per-channel write lines.
REQ-011 SHALL have port ready_o  out  NUM_REQ  per-channel one-cycle completion pulse.
REQ-012 SHALL have port rdata_o  out  LINE_W  read line returned to the completed channel.
REQ-013 SHALL have port mem_req  out  1  memory request level.
REQ-014 SHALL have port mem_we  out  1  memory write enable.
REQ-015 SHALL have port mem_addr  out  ADDR_W  memory line address.
REQ-016 SHALL have port mem_wdata  out  LINE_W  memory write line.
REQ-017 SHALL have port mem_rdata  in  LINE_W  memory read line, valid with mem_ready.
REQ-018 SHALL have port mem_ready  in  1  memory completion, one or more cycles high.
REQ-019 SHALL have port mem_req_reset  out  1  one-cycle pulse telling the LLC the request is retired.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY, RELEASE.
REQ-021 IDLE: if any req_i bit set, SHALL select a winner, latch index, we, addr, wdata into registers and move to BUSY on that edge.
REQ-022 RR_MODE=1: winner SHALL be the first set req_i bit at or after pointer rr_ptr, wrapping modulo NUM_REQ; rr_ptr SHALL become winner+1 (wrapping NUM_REQ-1 -> 0) at grant.
REQ-023 RR_MODE=0: winner SHALL be the lowest set index; rr_ptr is unused.
REQ-024 BUSY: mem_req=1, and mem_we/mem_addr/mem_wdata SHALL drive the latched values, stable for the whole state.
REQ-025 BUSY with mem_ready=1: SHALL register mem_rdata into rdata_o, pulse ready_o[winner] and mem_req_reset for exactly the next cycle, and enter RELEASE.
REQ-026 RELEASE: mem_req=0, lasting exactly one cycle, then IDLE; mem_ready still high here SHALL be ignored.
REQ-027 Latency: req_i at edge 0 in IDLE -> mem_req high after edge 1; mem_ready sampled at edge k -> ready_o high during cycle after edge k; minimum 3 cycles per transaction.
REQ-028 rdata_o SHALL hold its value until the next read completion; write completions SHALL NOT update rdata_o.
REQ-029 A req_i deassert during BUSY SHALL NOT abort the transaction; it completes and ready_o still pulses.
REQ-030 Requests arriving during BUSY/RELEASE SHALL wait; at most one transaction outstanding.
REQ-031 ready_o SHALL be one-hot or zero at all times.
REQ-032 Under continuous requests from all channels in RR_MODE=1, each channel SHALL be granted once per NUM_REQ grants.

Reset
REQ-033 rst SHALL force state IDLE, rr_ptr 0, ready_o 0, rdata_o 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_req_reset 0 at the next edge.
REQ-034 rst mid-BUSY SHALL drop the transaction without ready_o or mem_req_reset pulses.

Structure
REQ-035 State encoding and the RR_MODE values SHALL live in the shared definitions file.
REQ-036 Winner selection SHALL be a sub-module rr_pick (combinational, inputs req and pointer, output index and valid).

Verification
REQ-037 Single read: ch0 req, addr 0x00040, mem_ready after 4 cycles with 0xDEAD...BEEF -> mem_addr=0x00040, mem_we=0, ready_o=01 one cycle, rdata_o=0xDEAD...BEEF, mem_req_reset one pulse.
REQ-038 Collision RR: NUM_REQ=2, both req from reset -> grants ch0 then ch1 then ch0; ready_o sequence 01,10,01.
REQ-039 Fixed priority: RR_MODE=0, both req held -> ch0 granted every time, ch1 never.
REQ-040 Write: ch1 we=1, addr 0x000A0, wdata 0x1111...1111 -> mem_we=1 with those values; rdata_o unchanged; ready_o=10.
REQ-041 Wrap: NUM_REQ=4, rr_ptr=3, req_i=1001 -> ch3 granted, rr_ptr=0, then ch0.
REQ-042 Reset mid-BUSY: rst in 2nd BUSY cycle -> mem_req=0 next edge, no ready_o pulse, next request granted normally.
